// File: rtl/pc_sequencer.sv
// Program counter and sequencing control: relative branch, absolute jump,
// call/return through a small return-address stack, and run/halt status.
module pc_sequencer #(
    parameter int D  = 12,
    parameter int SD = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Halt,
    input  logic [D-1:0]      Target,
    output logic [D-1:0]      ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic              StackErr,
    output logic [$clog2(SD):0] StackLvl
);

    localparam int AW = $clog2(SD);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         r_state;
    logic [D-1:0]   r_pc;
    logic [LW-1:0]  r_lvl;
    logic           r_err;
    logic           r_running;
    logic           r_done;
    logic [D-1:0]   r_stack [SD];

    state_t         w_state_nxt;
    logic [D-1:0]   w_pc_nxt;
    logic [LW-1:0]  w_lvl_nxt;
    logic           w_err_nxt;
    logic           w_push;
    logic [D-1:0]   w_pc_inc;
    logic [AW-1:0]  w_rd_idx;
    logic [AW-1:0]  w_wr_idx;
    logic           w_full;
    logic           w_empty;

    assign w_pc_inc = r_pc + D'(1);
    assign w_rd_idx = AW'(r_lvl - LW'(1));
    assign w_wr_idx = AW'(r_lvl);
    assign w_full   = (r_lvl == LW'(SD));
    assign w_empty  = (r_lvl == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lvl_nxt   = r_lvl;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_pc_nxt = '0;
                if (Start) w_state_nxt = S_RUN;
            end
            S_HALT: begin
                // Restart wipes the stack so a new program never inherits stale frames.
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_lvl_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (Halt) begin
                    w_state_nxt = S_HALT;
                end else if (Stall) begin
                    w_pc_nxt = r_pc;
                end else if (Ret) begin
                    if (w_empty) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt  = r_stack[w_rd_idx];
                        w_lvl_nxt = r_lvl - LW'(1);
                    end
                end else if (Call) begin
                    if (w_full) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_nxt  = Target;
                        w_lvl_nxt = r_lvl + LW'(1);
                    end
                end else if (Jump) begin
                    w_pc_nxt = Target;
                end else if (Branch) begin
                    // Two's-complement offset: plain modulo-2^D add covers negatives.
                    w_pc_nxt = r_pc + Target;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_lvl     <= '0;
            r_err     <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_lvl     <= w_lvl_nxt;
            r_err     <= w_err_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_HALT);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push && !Reset) r_stack[w_wr_idx] <= w_pc_inc;
    end

    assign ProgCtr  = r_pc;
    assign Running  = r_running;
    assign Done     = r_done;
    assign StackErr = r_err;
    assign StackLvl = r_lvl;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (D=12, SD=4).
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset, Start, Stall, Branch, Jump, Call, Ret, Halt;
    logic [11:0] Target;
    logic [11:0] ProgCtr;
    logic        Running, Done, StackErr;
    logic [2:0]  StackLvl;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer #(.D(12), .SD(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .Branch(Branch), .Jump(Jump), .Call(Call), .Ret(Ret), .Halt(Halt),
        .Target(Target), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
        .StackErr(StackErr), .StackLvl(StackLvl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        Reset = 0; Start = 0; Stall = 0; Branch = 0; Jump = 0;
        Call = 0; Ret = 0; Halt = 0; Target = '0;
    endtask

    // One clock: inputs already set are sampled at the edge, then released.
    task automatic tick();
        @(posedge Clk);
        #1;
        idle_inputs();
    endtask

    task automatic restart();
        Reset = 1; tick();
        Start = 1; tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1; Start = 1; Call = 1; Target = 12'd55;
        tick();
        n_cmp++; if (ProgCtr !== 12'd0) begin n_bad++; $display("FAIL reset_pc got %0d want 0", ProgCtr); end
        n_cmp++; if ({Running, Done, StackErr} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {Running, Done, StackErr}); end
        n_cmp++; if (StackLvl !== 3'd0) begin n_bad++; $display("FAIL reset_lvl got %0d want 0", StackLvl); end
        Jump = 1; Target = 12'd77; tick();
        n_cmp++; if (ProgCtr !== 12'd0 || Running !== 1'b0) begin n_bad++; $display("FAIL idle_ignores pc %0d run %b want 0 0", ProgCtr, Running); end
    endtask

    task automatic test_sequential();
        Start = 1; tick();
        n_cmp++; if (ProgCtr !== 12'd0 || Running !== 1'b1) begin n_bad++; $display("FAIL start pc %0d run %b want 0 1", ProgCtr, Running); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (ProgCtr !== 12'(i) || Running !== 1'b1 || Done !== 1'b0) begin
                n_bad++; $display("FAIL seq_step%0d pc %0d run %b done %b want %0d 1 0", i, ProgCtr, Running, Done, i);
            end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (ProgCtr !== 12'd10) begin n_bad++; $display("FAIL pre_branch got %0d want 10", ProgCtr); end
        Branch = 1; Target = 12'hFFB; tick();
        n_cmp++; if (ProgCtr !== 12'd5) begin n_bad++; $display("FAIL branch_neg got %0d want 5", ProgCtr); end
        Branch = 1; Target = 12'd20; tick();
        n_cmp++; if (ProgCtr !== 12'd25) begin n_bad++; $display("FAIL branch_pos got %0d want 25", ProgCtr); end
        Branch = 1; Target = 12'hFFF; tick();
        n_cmp++; if (ProgCtr !== 12'd24) begin n_bad++; $display("FAIL branch_m1 got %0d want 24", ProgCtr); end
    endtask

    task automatic test_priority();
        Jump = 1; Target = 12'd30; tick();
        Stall = 1; Branch = 1; Target = 12'd20; tick();
        n_cmp++; if (ProgCtr !== 12'd30) begin n_bad++; $display("FAIL stall_over_branch got %0d want 30", ProgCtr); end
        Jump = 1; Branch = 1; Target = 12'd100; tick();
        n_cmp++; if (ProgCtr !== 12'd100) begin n_bad++; $display("FAIL jump_over_branch got %0d want 100", ProgCtr); end
        Jump = 1; Target = 12'd4095; tick();
        n_cmp++; if (ProgCtr !== 12'd4095) begin n_bad++; $display("FAIL jump_max got %0d want 4095", ProgCtr); end
        tick();
        n_cmp++; if (ProgCtr !== 12'd0) begin n_bad++; $display("FAIL wrap got %0d want 0", ProgCtr); end
        Halt = 1; Stall = 1; Jump = 1; Target = 12'd9; tick();
        n_cmp++; if (ProgCtr !== 12'd0 || Done !== 1'b1) begin n_bad++; $display("FAIL halt_first pc %0d done %b want 0 1", ProgCtr, Done); end
    endtask

    task automatic test_stack();
        restart();
        Jump = 1; Target = 12'd16; tick();
        Call = 1; Jump = 1; Target = 12'd408; tick();
        n_cmp++; if (ProgCtr !== 12'd408 || StackLvl !== 3'd1) begin n_bad++; $display("FAIL call pc %0d lvl %0d want 408 1", ProgCtr, StackLvl); end
        Ret = 1; Call = 1; Target = 12'd9; tick();
        n_cmp++; if (ProgCtr !== 12'd17 || StackLvl !== 3'd0) begin n_bad++; $display("FAIL ret pc %0d lvl %0d want 17 0", ProgCtr, StackLvl); end
        for (int i = 1; i <= 4; i++) begin
            Call = 1; Target = 12'(100 * i); tick();
        end
        n_cmp++; if (ProgCtr !== 12'd400 || StackLvl !== 3'd4 || StackErr !== 1'b0) begin n_bad++; $display("FAIL nest4 pc %0d lvl %0d err %b want 400 4 0", ProgCtr, StackLvl, StackErr); end
        Call = 1; Target = 12'd500; tick();
        n_cmp++; if (StackErr !== 1'b1 || Done !== 1'b1 || Running !== 1'b0) begin n_bad++; $display("FAIL overflow err %b done %b run %b want 1 1 0", StackErr, Done, Running); end
        n_cmp++; if (ProgCtr !== 12'd400 || StackLvl !== 3'd4) begin n_bad++; $display("FAIL overflow_hold pc %0d lvl %0d want 400 4", ProgCtr, StackLvl); end
        Start = 1; tick();
        n_cmp++; if (ProgCtr !== 12'd0 || StackLvl !== 3'd0 || StackErr !== 1'b0 || Running !== 1'b1) begin n_bad++; $display("FAIL restart_clear pc %0d lvl %0d err %b run %b want 0 0 0 1", ProgCtr, StackLvl, StackErr, Running); end
    endtask

    task automatic test_underflow();
        restart();
        Ret = 1; tick();
        n_cmp++; if (StackErr !== 1'b1 || Done !== 1'b1 || ProgCtr !== 12'd0) begin n_bad++; $display("FAIL underflow err %b done %b pc %0d want 1 1 0", StackErr, Done, ProgCtr); end
        Start = 1; tick();
        n_cmp++; if (ProgCtr !== 12'd0 || StackErr !== 1'b0 || StackLvl !== 3'd0 || Running !== 1'b1 || Done !== 1'b0) begin n_bad++; $display("FAIL underflow_restart pc %0d err %b lvl %0d run %b done %b want 0 0 0 1 0", ProgCtr, StackErr, StackLvl, Running, Done); end
    endtask

    task automatic test_halt_and_reset();
        restart();
        Jump = 1; Target = 12'd7; tick();
        Halt = 1; tick();
        n_cmp++; if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 12'd7) begin n_bad++; $display("FAIL halt done %b run %b pc %0d want 1 0 7", Done, Running, ProgCtr); end
        for (int i = 0; i < 3; i++) begin
            Branch = 1; Jump = (i == 1); Call = (i == 2); Target = 12'd50; tick();
            n_cmp++; if (ProgCtr !== 12'd7 || Done !== 1'b1 || StackLvl !== 3'd0) begin n_bad++; $display("FAIL halt_frozen%0d pc %0d done %b lvl %0d want 7 1 0", i, ProgCtr, Done, StackLvl); end
        end
        Start = 1; tick();
        tick(); tick();
        Reset = 1; Call = 1; Target = 12'd300; tick();
        n_cmp++; if (ProgCtr !== 12'd0 || StackLvl !== 3'd0 || Running !== 1'b0 || Done !== 1'b0) begin n_bad++; $display("FAIL reset_mid_run pc %0d lvl %0d run %b done %b want 0 0 0 0", ProgCtr, StackLvl, Running, Done); end
    endtask

    task automatic test_back_to_back();
        restart();
        Jump = 1; Target = 12'd200; tick();
        Call = 1; Target = 12'd50; tick();
        Call = 1; Target = 12'd60; tick();
        n_cmp++; if (ProgCtr !== 12'd60 || StackLvl !== 3'd2) begin n_bad++; $display("FAIL b2b_calls pc %0d lvl %0d want 60 2", ProgCtr, StackLvl); end
        Ret = 1; tick();
        n_cmp++; if (ProgCtr !== 12'd51 || StackLvl !== 3'd1) begin n_bad++; $display("FAIL b2b_ret1 pc %0d lvl %0d want 51 1", ProgCtr, StackLvl); end
        Ret = 1; tick();
        n_cmp++; if (ProgCtr !== 12'd201 || StackLvl !== 3'd0) begin n_bad++; $display("FAIL b2b_ret2 pc %0d lvl %0d want 201 0", ProgCtr, StackLvl); end
        Branch = 1; Target = 12'h800; tick();
        n_cmp++; if (ProgCtr !== 12'd2249) begin n_bad++; $display("FAIL b2b_branch_min got %0d want 2249", ProgCtr); end
        Start = 1; tick();
        n_cmp++; if (ProgCtr !== 12'd2250 || Running !== 1'b1) begin n_bad++; $display("FAIL start_in_run pc %0d run %b want 2250 1", ProgCtr, Running); end
    endtask

    initial begin
        idle_inputs();
        @(negedge Clk);
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_stack();
        test_underflow();
        test_halt_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and sequencing control, directly downstream of the branch-target lookup table.
- Consumes the D-bit target word, applies it as a relative branch offset, an absolute jump target or a call target, and keeps a small return-address stack.
- Drives the instruction-fetch address and reports run/done status to the top level and testbench.

Parameters:
D, 12, PC and target width in bits; PC arithmetic is modulo 2^D.
SD, 4, return-stack depth (entries), power of two, 2..16.

Ports:
Clk  input  1  system clock, all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  begin execution at PC 0; honoured in IDLE and HALT only.
Stall  input  1  hold PC and stack this cycle (RUN only).
Branch  input  1  taken relative branch: PC <= PC + Target (Target signed, two's complement).
Jump  input  1  absolute jump: PC <= Target.
Call  input  1  push PC+1, then PC <= Target (absolute).
Ret  input  1  PC <= popped return address.
Halt  input  1  stop execution; PC frozen.
Target  input  D  target word from the lookup table.
ProgCtr  output  D  current fetch address (registered).
Running  output  1  high in RUN.
Done  output  1  high in HALT (registered).
StackErr  output  1  sticky: stack overflow or underflow occurred.
StackLvl  output  $clog2(SD)+1  number of valid stack entries.

Behaviour:
- Reset (sync, highest priority): state=IDLE, ProgCtr=0, StackLvl=0, StackErr=0, Running=0, Done=0. Reset asserted mid-RUN or mid-HALT takes effect at the next edge regardless of other inputs.
- IDLE: PC held at 0. Start=1 -> RUN next cycle with ProgCtr=0. All control inputs are ignored.
- RUN: exactly one action per edge, in this priority:
  1. Halt -> HALT, PC held.
  2. Stall -> hold PC and stack.
  3. Ret
  4. Call
  5. Jump
  6. Branch
  7. Default: PC+1.
  Lower-priority requests in the same cycle are dropped, not queued. Start is ignored in RUN.
- Arithmetic: Branch computes PC + Target truncated to D bits. Target all-ones = -1, so Branch with all-ones yields PC-1. PC+1 from 2^D-1 wraps to 0. Jump/Call load Target unsigned.
- Call: stores (PC+1) mod 2^D at stack[StackLvl], StackLvl+1, PC <= Target, all in one edge.
  - Call with StackLvl==SD (full): no push, PC held, StackErr=1, state -> HALT.
- Ret: PC <= stack[StackLvl-1], StackLvl-1, same edge.
  - Ret with StackLvl==0 (empty): PC held, StackErr=1, state -> HALT.
- HALT: Done=1, Running=0, PC frozen at the last value. Start=1 -> RUN at PC 0; the same edge clears stack, StackLvl and StackErr. Control inputs other than Start are ignored.
- Done and Running are registered state decodes, valid the cycle after the transition edge; no combinational input-to-output paths.
- Latency: a request sampled at edge N is reflected on ProgCtr after edge N, so fetch uses the new address in cycle N+1.

Test Plan:
1. Reset, then Start pulse -> ProgCtr 0; 5 plain cycles -> ProgCtr 5. Running=1, Done=0 throughout.
2. At PC 10, Branch with Target 12'hFFB (-5) -> PC 5. At PC 5, Branch with Target 20 -> PC 25. At PC 25, Branch with Target 12'hFFF -> PC 24.
3. Priority: at PC 30, Stall+Branch with Target 20 -> PC stays 30. Next cycle, Jump+Branch with Target 100 -> PC 100. At PC 4095 with no request -> PC 0 (wrap).
4. Return stack: Call with Target 408 from PC 16 -> PC 408, StackLvl 1. Ret -> PC 17, StackLvl 0. Five nested Calls with SD=4 -> fifth sets StackErr=1 and Done=1, PC unchanged, StackLvl 4.
5. From reset, Ret on empty stack in RUN -> StackErr=1, HALT. Start -> PC 0, StackErr=0, StackLvl=0, Running=1.
6. Halt at PC 7 -> Done=1 next cycle, PC stays 7 while Branch/Jump toggle. Reset asserted mid-RUN with Call active -> next cycle IDLE, PC 0, StackLvl 0, no push.
